// File: rtl/mem_arbiter_pkg.sv
// Shared constants and helpers for the multi-master memory arbiter.
package mem_arbiter_pkg;

   // Field widths of the controller request bus
   localparam int ADDR_W = 30;
   localparam int DATA_W = 32;
   localparam int MASK_W = 4;
   localparam int ID_W   = 2;
   localparam int PORT_W = 2;

   // Tag 0 on the return path means "no data this cycle"
   localparam logic [ID_W-1:0] ID_NONE = 2'd0;

   // Arbiter states, kept as plain encodings so older tools read them unchanged
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;

   // Requester index to bus tag; the tag is offset by one so that 0 stays free
   function automatic logic [ID_W-1:0] port_to_id(input logic [PORT_W-1:0] port);
      return port + 2'd1;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and controller-side signals around the arbiter.
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int NPORTS = 3
);

   // Requester side
   logic [NPORTS*ADDR_W-1:0] req_address;
   logic [NPORTS-1:0]        req_read;
   logic [NPORTS-1:0]        req_write;
   logic [NPORTS*DATA_W-1:0] req_writedata;
   logic [NPORTS*MASK_W-1:0] req_writedatamask;
   logic [NPORTS-1:0]        req_waitrequest;
   logic [DATA_W-1:0]        rsp_readdata;
   logic [NPORTS-1:0]        rsp_valid;
   logic                     protocol_error;

   // Controller side
   logic                     mem_waitrequest;
   logic [ID_W-1:0]          mem_id;
   logic [ADDR_W-1:0]        mem_address;
   logic                     mem_read;
   logic                     mem_write;
   logic [DATA_W-1:0]        mem_writedata;
   logic [MASK_W-1:0]        mem_writedatamask;
   logic [DATA_W-1:0]        mem_readdata;
   logic [ID_W-1:0]          mem_readdataid;

   // View of the surrounding system: requesters plus the memory controller
   modport master (
      output req_address, req_read, req_write, req_writedata, req_writedatamask,
      input  req_waitrequest, rsp_readdata, rsp_valid, protocol_error,
      output mem_waitrequest, mem_readdata, mem_readdataid,
      input  mem_id, mem_address, mem_read, mem_write, mem_writedata, mem_writedatamask
   );

   // View of the arbiter itself
   modport slave (
      input  req_address, req_read, req_write, req_writedata, req_writedatamask,
      output req_waitrequest, rsp_readdata, rsp_valid, protocol_error,
      input  mem_waitrequest, mem_readdata, mem_readdataid,
      output mem_id, mem_address, mem_read, mem_write, mem_writedata, mem_writedatamask
   );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker: first eligible requester at or after the pointer wins.
module rr_pick
   import mem_arbiter_pkg::*;
#(
   parameter int NPORTS = 3
) (
   input  logic [NPORTS-1:0] eligible_i,
   input  logic [PORT_W-1:0] ptr_i,
   output logic [NPORTS-1:0] grant_o,
   output logic              valid_o
);

   localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

   logic [IDX_W-1:0] idx;

   // Walk the ports starting at the pointer and latch onto the first eligible one
   always_comb begin
      grant_o = '0;
      valid_o = 1'b0;
      idx     = '0;
      for (int off = 0; off < NPORTS; off++) begin
         idx = IDX_W'((int'(ptr_i) + off) % NPORTS);
         if (!valid_o && eligible_i[idx]) begin
            grant_o[idx] = 1'b1;
            valid_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-master front end: round-robin request issue onto the SSRAM/flash
// controller bus and tag-based routing of returned read words.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int NPORTS      = 3,
   parameter int BURST_WORDS = 4,
   parameter int CNT_W       = 3
) (
   input  logic          clock,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);

   logic [0:0]        state_q, state_d;
   logic [PORT_W-1:0] grant_q, grant_d;
   logic [PORT_W-1:0] ptr_q, ptr_d;
   logic              memRead_q, memRead_d;
   logic              memWrite_q, memWrite_d;
   logic [ID_W-1:0]   memId_q, memId_d;
   logic [ADDR_W-1:0] memAddress_q, memAddress_d;
   logic [DATA_W-1:0] memWritedata_q, memWritedata_d;
   logic [MASK_W-1:0] memMask_q, memMask_d;

   logic [CNT_W-1:0]  outCnt_q [NPORTS];
   logic [CNT_W-1:0]  outCnt_d [NPORTS];
   logic [NPORTS-1:0] rspValid_q, rspValid_d;
   logic [DATA_W-1:0] rspReaddata_q, rspReaddata_d;
   logic              protocolError_q, protocolError_d;

   logic [NPORTS-1:0] eligible;
   logic [NPORTS-1:0] pickOneHot;
   logic              pickValid;
   logic [PORT_W-1:0] pickIdx;
   logic [PORT_W-1:0] retIdx;
   logic              readAccept;

   // A port may compete for a write at any time, but a read only once its previous burst has fully drained
   always_comb begin
      eligible = '0;
      for (int p = 0; p < NPORTS; p++) begin
         eligible[p] = bus.req_write[p] | (bus.req_read[p] & (outCnt_q[p] == '0));
      end
   end

   rr_pick #(
      .NPORTS (NPORTS)
   ) u_rr_pick (
      .eligible_i (eligible),
      .ptr_i      (ptr_q),
      .grant_o    (pickOneHot),
      .valid_o    (pickValid)
   );

   // Turn the one-hot pick into a port index for muxing and tagging
   always_comb begin
      pickIdx = '0;
      for (int p = 0; p < NPORTS; p++) begin
         if (pickOneHot[p]) pickIdx = PORT_W'(p);
      end
   end

   // Request path: capture the winner in IDLE, hold it stable in ISSUE until the controller takes it
   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      ptr_d          = ptr_q;
      memRead_d      = memRead_q;
      memWrite_d     = memWrite_q;
      memId_d        = memId_q;
      memAddress_d   = memAddress_q;
      memWritedata_d = memWritedata_q;
      memMask_d      = memMask_q;
      case (state_q)
         ST_IDLE: begin
            memRead_d  = 1'b0;
            memWrite_d = 1'b0;
            if (pickValid) begin
               grant_d    = pickIdx;
               memId_d    = port_to_id(pickIdx);
               memWrite_d = bus.req_write[pickIdx];
               memRead_d  = !bus.req_write[pickIdx];
               for (int p = 0; p < NPORTS; p++) begin
                  if (pickIdx == PORT_W'(p)) begin
                     memAddress_d   = bus.req_address[p*ADDR_W +: ADDR_W];
                     memWritedata_d = bus.req_writedata[p*DATA_W +: DATA_W];
                     memMask_d      = bus.req_writedatamask[p*MASK_W +: MASK_W];
                  end
               end
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!bus.mem_waitrequest) begin
               memRead_d  = 1'b0;
               memWrite_d = 1'b0;
               ptr_d      = (grant_q == PORT_W'(NPORTS - 1)) ? '0 : grant_q + 2'd1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign readAccept = (state_q == ST_ISSUE) && !bus.mem_waitrequest && memRead_q;
   assign retIdx     = bus.mem_readdataid - 2'd1;

   // Return path: route tagged words to their owner, count the burst down, flag anything unexpected
   always_comb begin
      outCnt_d        = outCnt_q;
      rspValid_d      = '0;
      rspReaddata_d   = rspReaddata_q;
      protocolError_d = protocolError_q;
      if (bus.mem_readdataid != ID_NONE) begin
         if (int'(bus.mem_readdataid) > NPORTS) begin
            protocolError_d = 1'b1;
         end else if (outCnt_q[retIdx] == '0) begin
            protocolError_d = 1'b1;
         end else begin
            rspValid_d[retIdx] = 1'b1;
            rspReaddata_d      = bus.mem_readdata;
            outCnt_d[retIdx]   = outCnt_q[retIdx] - 1'b1;
         end
      end
      if (readAccept) outCnt_d[grant_q] = CNT_W'(BURST_WORDS);
   end

   // Register the arbitration state and the issued request fields
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         grant_q        <= '0;
         ptr_q          <= '0;
         memRead_q      <= 1'b0;
         memWrite_q     <= 1'b0;
         memId_q        <= ID_NONE;
         memAddress_q   <= '0;
         memWritedata_q <= '0;
         memMask_q      <= '0;
      end else begin
         state_q        <= state_d;
         grant_q        <= grant_d;
         ptr_q          <= ptr_d;
         memRead_q      <= memRead_d;
         memWrite_q     <= memWrite_d;
         memId_q        <= memId_d;
         memAddress_q   <= memAddress_d;
         memWritedata_q <= memWritedata_d;
         memMask_q      <= memMask_d;
      end
   end

   // Register the outstanding counters and the response outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         outCnt_q        <= '{default: '0};
         rspValid_q      <= '0;
         rspReaddata_q   <= '0;
         protocolError_q <= 1'b0;
      end else begin
         outCnt_q        <= outCnt_d;
         rspValid_q      <= rspValid_d;
         rspReaddata_q   <= rspReaddata_d;
         protocolError_q <= protocolError_d;
      end
   end

   // Acceptance is visible to the requester in the same cycle the controller drops its stall
   always_comb begin
      bus.req_waitrequest = '1;
      for (int p = 0; p < NPORTS; p++) begin
         bus.req_waitrequest[p] = !((state_q == ST_ISSUE) && (grant_q == PORT_W'(p)) && !bus.mem_waitrequest);
      end
   end

   assign bus.mem_read          = memRead_q;
   assign bus.mem_write         = memWrite_q;
   assign bus.mem_id            = memId_q;
   assign bus.mem_address       = memAddress_q;
   assign bus.mem_writedata     = memWritedata_q;
   assign bus.mem_writedatamask = memMask_q;
   assign bus.rsp_valid         = rspValid_q;
   assign bus.rsp_readdata      = rspReaddata_q;
   assign bus.protocol_error    = protocolError_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

   logic clock;
   logic reset;

   int assertCount = 0;
   int failCount   = 0;

   logic [29:0] portAddr [3] = '{30'h100, 30'h200, 30'h300};
   logic [31:0] portData [3] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002};
   logic [3:0]  portMask [3] = '{4'hF, 4'h3, 4'hC};

   mem_arbiter_if #(.NPORTS(3)) bus ();

   mem_arbiter #(
      .NPORTS      (3),
      .BURST_WORDS (4),
      .CNT_W       (3)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Free-running 10-unit clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Count one comparison and report it when observed and expected differ
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drive request vectors and controller-side inputs, then let the combinational paths settle
   task automatic applyStimulus(input logic [2:0] rd, input logic [2:0] wr, input logic waitReq,
                                input logic [1:0] id, input logic [31:0] data);
      bus.req_read        = rd;
      bus.req_write       = wr;
      bus.mem_waitrequest = waitReq;
      bus.mem_readdataid  = id;
      bus.mem_readdata    = data;
      #1;
   endtask

   // One full grant with no controller stall: expect port's fields on the bus, then a clean drop
   task automatic issueAndAccept(input string tag, input int port, input logic isRead,
                                 input logic [2:0] rd, input logic [2:0] wr,
                                 input logic [2:0] rdAfter, input logic [2:0] wrAfter);
      logic [2:0] expWait;
      expWait       = 3'b111;
      expWait[port] = 1'b0;
      applyStimulus(rd, wr, 1'b0, 2'd0, 32'h0);
      tick();
      applyStimulus(rd, wr, 1'b0, 2'd0, 32'h0);
      checkOutput({tag, ".id"},    32'(bus.mem_id),          32'(port + 1));
      checkOutput({tag, ".read"},  32'(bus.mem_read),        32'(isRead));
      checkOutput({tag, ".write"}, 32'(bus.mem_write),       32'(!isRead));
      checkOutput({tag, ".addr"},  32'(bus.mem_address),     32'(portAddr[port]));
      checkOutput({tag, ".wait"},  32'(bus.req_waitrequest), 32'(expWait));
      if (!isRead) begin
         checkOutput({tag, ".wdata"}, bus.mem_writedata,          portData[port]);
         checkOutput({tag, ".mask"},  32'(bus.mem_writedatamask), 32'(portMask[port]));
      end
      tick();
      applyStimulus(rdAfter, wrAfter, 1'b0, 2'd0, 32'h0);
      checkOutput({tag, ".dropRead"},  32'(bus.mem_read),  32'd0);
      checkOutput({tag, ".dropWrite"}, 32'(bus.mem_write), 32'd0);
   endtask

   // Hold reset across two edges and check every reset-cleared output
   task automatic resetPulse(input string tag);
      reset = 1'b1;
      applyStimulus(3'b000, 3'b000, 1'b0, 2'd0, 32'h0);
      tick();
      tick();
      checkOutput({tag, ".read"},  32'(bus.mem_read),       32'd0);
      checkOutput({tag, ".write"}, 32'(bus.mem_write),      32'd0);
      checkOutput({tag, ".id"},    32'(bus.mem_id),         32'd0);
      checkOutput({tag, ".addr"},  32'(bus.mem_address),    32'd0);
      checkOutput({tag, ".valid"}, 32'(bus.rsp_valid),      32'd0);
      checkOutput({tag, ".rdata"}, bus.rsp_readdata,        32'd0);
      checkOutput({tag, ".perr"},  32'(bus.protocol_error), 32'd0);
      reset = 1'b0;
   endtask

   // Directed scenario sequence
   initial begin
      reset = 1'b0;
      for (int p = 0; p < 3; p++) begin
         bus.req_address[p*30 +: 30]      = portAddr[p];
         bus.req_writedata[p*32 +: 32]    = portData[p];
         bus.req_writedatamask[p*4 +: 4]  = portMask[p];
      end
      applyStimulus(3'b000, 3'b000, 1'b0, 2'd0, 32'h0);
      #1;
      resetPulse("rst0");

      // Port0 read stalled three cycles, then a four-word burst back
      applyStimulus(3'b001, 3'b000, 1'b1, 2'd0, 32'h0);
      tick();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(3'b001, 3'b000, (i < 3), 2'd0, 32'h0);
         checkOutput($sformatf("t1.hold%0d.read", i), 32'(bus.mem_read), 32'd1);
         checkOutput($sformatf("t1.hold%0d.id", i),   32'(bus.mem_id),   32'd1);
         checkOutput($sformatf("t1.hold%0d.addr", i), 32'(bus.mem_address), 32'h100);
         checkOutput($sformatf("t1.hold%0d.wait", i), 32'(bus.req_waitrequest),
                     (i < 3) ? 32'h7 : 32'h6);
         tick();
      end
      applyStimulus(3'b000, 3'b000, 1'b0, 2'd0, 32'h0);
      checkOutput("t1.drop", 32'(bus.mem_read), 32'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(3'b000, 3'b000, 1'b0, 2'd1, 32'hA000_0000 + 32'(i));
         if (i == 0) checkOutput("t1.latency", 32'(bus.rsp_valid), 32'd0);
         tick();
         checkOutput($sformatf("t1.word%0d.valid", i), 32'(bus.rsp_valid), 32'h1);
         checkOutput($sformatf("t1.word%0d.data", i),  bus.rsp_readdata,   32'hA000_0000 + 32'(i));
      end
      applyStimulus(3'b000, 3'b000, 1'b0, 2'd0, 32'h0);
      tick();
      checkOutput("t1.idleValid", 32'(bus.rsp_valid),      32'd0);
      checkOutput("t1.perr",      32'(bus.protocol_error), 32'd0);

      // Three simultaneous writers rotate 0,1,2, then port0 comes back first
      resetPulse("rst1");
      issueAndAccept("t2.g0", 0, 1'b0, 3'b000, 3'b111, 3'b000, 3'b110);
      issueAndAccept("t2.g1", 1, 1'b0, 3'b000, 3'b110, 3'b000, 3'b100);
      issueAndAccept("t2.g2", 2, 1'b0, 3'b000, 3'b100, 3'b000, 3'b000);
      issueAndAccept("t2.g0b", 0, 1'b0, 3'b000, 3'b001, 3'b000, 3'b000);

      // Port1 reads, re-requests at once; port2 writes in between, port1 waits for its burst
      issueAndAccept("t3.rd1", 1, 1'b1, 3'b010, 3'b000, 3'b010, 3'b100);
      issueAndAccept("t3.wr2", 2, 1'b0, 3'b010, 3'b100, 3'b010, 3'b000);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(3'b010, 3'b000, 1'b0, 2'd2, 32'hC000_0000 + 32'(i));
         tick();
         checkOutput($sformatf("t3.word%0d.valid", i), 32'(bus.rsp_valid), 32'h2);
         checkOutput($sformatf("t3.word%0d.data", i),  bus.rsp_readdata,   32'hC000_0000 + 32'(i));
         checkOutput($sformatf("t3.word%0d.noIssue", i), 32'(bus.mem_read), 32'd0);
      end
      issueAndAccept("t3.rd1b", 1, 1'b1, 3'b010, 3'b000, 3'b000, 3'b000);

      // Tag 0 carries nothing: no response and port1 still expects all four words
      for (int i = 0; i < 3; i++) begin
         applyStimulus(3'b000, 3'b000, 1'b0, 2'd0, $urandom);
         tick();
         checkOutput($sformatf("t5.none%0d.valid", i), 32'(bus.rsp_valid), 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(3'b000, 3'b000, 1'b0, 2'd2, 32'hB000_0000 + 32'(i));
         tick();
         checkOutput($sformatf("t5.word%0d.valid", i), 32'(bus.rsp_valid), 32'h2);
         checkOutput($sformatf("t5.word%0d.data", i),  bus.rsp_readdata,   32'hB000_0000 + 32'(i));
      end
      checkOutput("t5.perr", 32'(bus.protocol_error), 32'd0);

      // Stray tag 3 while port2 has nothing outstanding is dropped and flagged for good
      applyStimulus(3'b000, 3'b000, 1'b0, 2'd3, 32'hDEAD_BEEF);
      tick();
      checkOutput("t4.valid", 32'(bus.rsp_valid),      32'd0);
      checkOutput("t4.perr",  32'(bus.protocol_error), 32'd1);
      checkOutput("t4.rdata", bus.rsp_readdata,        32'hB000_0003);
      applyStimulus(3'b000, 3'b000, 1'b0, 2'd0, 32'h0);
      tick();
      tick();
      checkOutput("t4.sticky", 32'(bus.protocol_error), 32'd1);

      // Reset in the middle of an issue with port2 still owed a burst
      issueAndAccept("t6.rd2", 2, 1'b1, 3'b100, 3'b000, 3'b000, 3'b000);
      applyStimulus(3'b001, 3'b000, 1'b1, 2'd0, 32'h0);
      tick();
      applyStimulus(3'b001, 3'b000, 1'b1, 2'd0, 32'h0);
      checkOutput("t6.preRead", 32'(bus.mem_read), 32'd1);
      checkOutput("t6.preId",   32'(bus.mem_id),   32'd1);
      reset = 1'b1;
      #1;
      checkOutput("t6.asyncRead", 32'(bus.mem_read),       32'd0);
      checkOutput("t6.asyncId",   32'(bus.mem_id),         32'd0);
      checkOutput("t6.asyncPerr", 32'(bus.protocol_error), 32'd0);
      tick();
      reset = 1'b0;
      issueAndAccept("t6.after0", 0, 1'b1, 3'b101, 3'b000, 3'b100, 3'b000);
      issueAndAccept("t6.after2", 2, 1'b1, 3'b100, 3'b000, 3'b000, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
